// File: rtl/ysyx_25060170_alu_pkg.sv
// Shared ALU arbiter definitions: datapath width, opcode encodings and FSM states.
package ysyx_25060170_alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_EQ  = 4'd4;
  localparam logic [3:0] ALU_LTU = 4'd5;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_EXEC = 2'd1;
  localparam state_t S_RESP = 2'd2;

endpackage

// File: rtl/ysyx_25060170_alu_core.sv
// Purely combinational ALU evaluator; opcodes outside the defined set yield zero.
module ysyx_25060170_alu_core
  import ysyx_25060170_alu_pkg::*;
(
  input  logic [3:0]      opc,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res
);

  always_comb begin
    res = '0;
    case (opc)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_OR:  res = a | b;
      ALU_AND: res = a & b;
      ALU_EQ:  res = {{(XLEN-1){1'b0}}, (a == b)};
      ALU_LTU: res = {{(XLEN-1){1'b0}}, (a < b)};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_25060170_alu_arb.sv
// Two-requester ALU arbiter with an IDLE -> EXEC -> RESP pipeline around one shared ALU.
// Define YSYX_25060170_ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module ysyx_25060170_alu_arb
  import ysyx_25060170_alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [7:0]        req_opc,
  input  logic [63:0]       req_a,
  input  logic [63:0]       req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [XLEN-1:0]   resp_res,
  output logic              resp_zero,
  output logic              resp_less,
  output logic              busy
);

  state_t            state;
  logic [1:0]        grant;
  logic              grant_id;
  logic [3:0]        opc_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   alu_res;

`ifdef YSYX_25060170_ALU_ARB_RR_EN
  logic              last_grant;
`endif

  // Grant is combinational so a requester sees ready in the same IDLE cycle it raises valid.
  always_comb begin
    grant = 2'b00;
    if (state == S_IDLE) begin
`ifdef YSYX_25060170_ALU_ARB_RR_EN
      if (&req_valid)
        grant = last_grant ? 2'b01 : 2'b10;
      else
        grant = req_valid;
`else
      if (req_valid[0])
        grant = 2'b01;
      else if (req_valid[1])
        grant = 2'b10;
`endif
    end
  end

  assign grant_id   = grant[1];
  assign req_ready  = grant;
  assign resp_valid = (state == S_RESP);
  assign busy       = (state != S_IDLE);

  ysyx_25060170_alu_core u_alu_core (
    .opc (opc_q),
    .a   (a_q),
    .b   (b_q),
    .res (alu_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      opc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      resp_id   <= 1'b0;
      resp_res  <= '0;
      resp_zero <= 1'b0;
      resp_less <= 1'b0;
`ifdef YSYX_25060170_ALU_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|grant) begin
            opc_q   <= req_opc[4*grant_id +: 4];
            a_q     <= req_a[XLEN*grant_id +: XLEN];
            b_q     <= req_b[XLEN*grant_id +: XLEN];
            resp_id <= grant_id;
            state   <= S_EXEC;
`ifdef YSYX_25060170_ALU_ARB_RR_EN
            last_grant <= grant_id;
`endif
          end
        end
        S_EXEC: begin
          resp_res  <= alu_res;
          resp_zero <= (alu_res == '0);
          resp_less <= alu_res[XLEN-1];
          state     <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_alu_arb.sv
// Directed self-checking bench for ysyx_25060170_alu_arb (honours YSYX_25060170_ALU_ARB_RR_EN).
module tb_ysyx_25060170_alu_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_opc;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_res;
  logic        resp_zero;
  logic        resp_less;
  logic        busy;

  int checks;
  int errors;

  ysyx_25060170_alu_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opc    (req_opc),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_res   (resp_res),
    .resp_zero  (resp_zero),
    .resp_less  (resp_less),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int id, input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
    req_opc[4*id +: 4] = opc;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
  endtask

  // One full transaction from a single requester with resp_ready held high.
  task automatic applyStimulus(input int id, input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input logic exp_zero, input logic exp_less);
    setReq(id, opc, a, b);
    req_valid = 2'b01 << id;
    resp_ready = 1'b1;
    #1;
    checkOutput("grant", req_ready, 2'b01 << id);
    tick();
    req_valid = 2'b00;
    #1;
    checkOutput("exec_valid", resp_valid, 0);
    checkOutput("exec_busy", busy, 1);
    checkOutput("exec_ready", req_ready, 0);
    tick();
    #1;
    checkOutput("resp_valid", resp_valid, 1);
    checkOutput("resp_res", resp_res, exp_res);
    checkOutput("resp_id", resp_id, id);
    checkOutput("resp_zero", resp_zero, exp_zero);
    checkOutput("resp_less", resp_less, exp_less);
    tick();
    #1;
    checkOutput("post_valid", resp_valid, 0);
    checkOutput("post_busy", busy, 0);
  endtask

  logic [1:0]  exp_grant [4];
  logic [31:0] held_res;
  logic [1:0]  exp_resume;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req_valid = 2'b00;
    req_opc = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
`ifdef YSYX_25060170_ALU_ARB_RR_EN
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
    exp_resume = 2'b10;
`else
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01; exp_grant[3] = 2'b01;
    exp_resume = 2'b01;
`endif

    tick();
    checkOutput("rst_valid", resp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_res", resp_res, 0);
    checkOutput("rst_id", resp_id, 0);
    checkOutput("rst_zero", resp_zero, 0);
    checkOutput("rst_less", resp_less, 0);
    rst = 1'b0;
    tick();

    applyStimulus(0, 4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    applyStimulus(1, 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b1);
    applyStimulus(1, 4'd4, 32'd9, 32'd9, 32'd1, 1'b0, 1'b0);
    applyStimulus(1, 4'd9, 32'd9, 32'd4, 32'd0, 1'b1, 1'b0);
    applyStimulus(0, 4'd2, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0);
    applyStimulus(1, 4'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
    applyStimulus(0, 4'd5, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    applyStimulus(1, 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    applyStimulus(0, 4'd4, 32'd9, 32'd8, 32'd0, 1'b1, 1'b0);

    // Fresh reset so the round-robin pointer starts from its reset value.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    setReq(0, 4'd0, 32'd1, 32'd1);
    setReq(1, 4'd0, 32'd2, 32'd2);
    req_valid = 2'b11;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("arb_grant", req_ready, exp_grant[k]);
      tick();
      checkOutput("arb_exec_ready", req_ready, 0);
      tick();
      checkOutput("arb_resp_id", resp_id, exp_grant[k][1]);
      checkOutput("arb_resp_res", resp_res, exp_grant[k][1] ? 32'd4 : 32'd2);
      tick();
    end
    req_valid = 2'b00;
    tick();

    // Stalled consumer: response must hold while other requesters wait.
    setReq(0, 4'd2, 32'h1234_0000, 32'h0000_5678);
    req_valid = 2'b01;
    resp_ready = 1'b0;
    #1;
    checkOutput("stall_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b11;
    tick();
    held_res = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_valid", resp_valid, 1);
      checkOutput("stall_res", resp_res, held_res);
      checkOutput("stall_ready", req_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    checkOutput("resume_grant", req_ready, exp_resume);
    req_valid = 2'b00;
    #1;
    checkOutput("drop_ready", req_ready, 0);
    tick();
    checkOutput("drop_busy", busy, 0);

    // Reset in EXEC discards the op and clears the held response.
    setReq(1, 4'd0, 32'd100, 32'd1);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    checkOutput("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_valid", resp_valid, 0);
    checkOutput("mid_rst_res", resp_res, 0);
    checkOutput("mid_rst_id", resp_id, 0);
    rst = 1'b0;
    tick();
    checkOutput("after_rst_valid", resp_valid, 0);
    tick();
    checkOutput("after_rst_valid2", resp_valid, 0);
    applyStimulus(1, 4'd0, 32'd100, 32'd1, 32'd101, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
